// File: rtl/datapath_pkg.sv
// Shared datapath constants: widths, architectural register indices and reset values.
// Imported by the register file, the ALU and the control unit.
package datapath_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_GP   = 28;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   localparam logic [31:0] SP_RESET_DEF = 32'h0000_3FFC;

endpackage

// File: rtl/reg_read_port.sv
// One register-file read port: forces index 0 to zero and optionally forwards
// the value being written this cycle.
module reg_read_port
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH,
   parameter bit BYPASS     = 1'b1
) (
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_WIDTH-1:0] stored,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] data
);

   logic hit;

   // A write to register 0 is dropped, so it must never be forwarded either.
   assign hit = BYPASS && wr_en && (wr_idx != '0) && (wr_idx == idx);

   always_comb begin
      data = '0;
      if (idx == '0)
         data = '0;
      else if (hit)
         data = wr_data;
      else
         data = stored;
   end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS general-purpose register file: two bypassable read ports, one
// unbypassed debug port, one write port and a committed-write counter.
module reg_file
   import datapath_pkg::*;
#(
   parameter int                    DATA_WIDTH = datapath_pkg::DATA_WIDTH,
   parameter int                    ADDR_WIDTH = datapath_pkg::ADDR_WIDTH,
   parameter bit                    BYPASS     = 1'b1,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = SP_RESET_DEF
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  regWrite,
   input  logic [ADDR_WIDTH-1:0] readReg1,
   input  logic [ADDR_WIDTH-1:0] readReg2,
   input  logic [ADDR_WIDTH-1:0] writeReg,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] dbgReg,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   output logic [DATA_WIDTH-1:0] dbgData,
   output logic [15:0]           writeCount
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  commit;

   assign commit = regWrite && (writeReg != '0);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (i == REG_SP) ? SP_RESET : '0;
         writeCount <= '0;
      end else if (commit) begin
         mem[writeReg] <= writeData;
         writeCount    <= writeCount + 16'd1;
      end
   end

   reg_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
   ) u_port1 (
      .idx    (readReg1),
      .stored (mem[readReg1]),
      .wr_en  (regWrite),
      .wr_idx (writeReg),
      .wr_data(writeData),
      .data   (readData1)
   );

   reg_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
   ) u_port2 (
      .idx    (readReg2),
      .stored (mem[readReg2]),
      .wr_en  (regWrite),
      .wr_idx (writeReg),
      .wr_data(writeData),
      .data   (readData2)
   );

   // Entry 0 is never written, so the debug port can read the array as-is.
   assign dbgData = mem[dbgReg];

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file: one bypassing and one non-bypassing
// instance share stimulus and are checked against an array-based model.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        regWrite = 1'b0;
   logic [4:0]  readReg1 = '0, readReg2 = '0, writeReg = '0, dbgReg = '0;
   logic [31:0] writeData = '0;
   logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
   logic [15:0] cnt_b, cnt_n;

   always #5 clk = ~clk;

   reg_file #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .rstN(rstN), .regWrite(regWrite), .readReg1(readReg1),
      .readReg2(readReg2), .writeReg(writeReg), .writeData(writeData),
      .dbgReg(dbgReg), .readData1(rd1_b), .readData2(rd2_b),
      .dbgData(dbg_b), .writeCount(cnt_b)
   );

   reg_file #(.BYPASS(1'b0)) dut_n (
      .clk(clk), .rstN(rstN), .regWrite(regWrite), .readReg1(readReg1),
      .readReg2(readReg2), .writeReg(writeReg), .writeData(writeData),
      .dbgReg(dbgReg), .readData1(rd1_n), .readData2(rd2_n),
      .dbgData(dbg_n), .writeCount(cnt_n)
   );

   typedef struct {
      logic [31:0] r1b, r2b, r1n, r2n, dbg;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: plain array of register values plus a write counter.
   logic [31:0] model_mem [32];
   logic [15:0] model_cnt;
   bit          prev_rst_n = 1'b0;
   bit          prev_we = 1'b0;
   logic [4:0]  prev_wa = '0;
   logic [31:0] prev_wd = '0;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
      model_mem[29] = 32'h0000_3FFC;
      model_cnt = 16'h0;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp);
      if (idx == 5'd0) return 32'h0;
      if (byp && regWrite && writeReg != 5'd0 && writeReg == idx) return writeData;
      return model_mem[idx];
   endfunction

   task automatic step(input bit rst_n_v, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d);
      exp_t e;
      @(posedge clk);
      #1;
      // Apply whatever the DUT should have committed on the edge just passed.
      if (prev_rst_n && prev_we && prev_wa != 5'd0) begin
         model_mem[prev_wa] = prev_wd;
         model_cnt = model_cnt + 16'd1;
      end
      rstN = rst_n_v; regWrite = we; writeReg = wa; writeData = wd;
      readReg1 = a1; readReg2 = a2; dbgReg = d;
      if (!rst_n_v) model_reset();
      prev_rst_n = rst_n_v; prev_we = we; prev_wa = wa; prev_wd = wd;
      e.r1b = model_read(a1, 1'b1);
      e.r2b = model_read(a2, 1'b1);
      e.r1n = model_read(a1, 1'b0);
      e.r2n = model_read(a2, 1'b0);
      e.dbg = (d == 5'd0) ? 32'h0 : model_mem[d];
      e.cnt = model_cnt;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd1_byp", rd1_b, e.r1b);
            chk("rd2_byp", rd2_b, e.r2b);
            chk("rd1_nobyp", rd1_n, e.r1n);
            chk("rd2_nobyp", rd2_n, e.r2n);
            chk("dbg_byp", dbg_b, e.dbg);
            chk("dbg_nobyp", dbg_n, e.dbg);
            chk("cnt_byp", {16'h0, cnt_b}, {16'h0, e.cnt});
            chk("cnt_nobyp", {16'h0, cnt_n}, {16'h0, e.cnt});
         end
      end
   end

   logic [4:0] pick [8];

   initial begin
      logic [4:0] wa, a1, a2;
      model_reset();
      pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd3; pick[3] = 5'd8;
      pick[4] = 5'd9; pick[5] = 5'd29; pick[6] = 5'd31; pick[7] = 5'd28;

      // Reset values through the debug port.
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd29, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 5'd29);
      // Basic write then read.
      step(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0, 5'd8);
      // Register 0 protection.
      step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 5'd0);
      // Bypass scenario on register 9.
      step(1'b1, 1'b1, 5'd9, 32'h1, 5'd1, 5'd2, 5'd9);
      step(1'b1, 1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 5'd9);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
      // Async reset between edges discards the pending write.
      step(1'b1, 1'b1, 5'd3, 32'hA5, 5'd1, 5'd2, 5'd3);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
      step(1'b0, 1'b1, 5'd3, 32'h77, 5'd3, 5'd3, 5'd3);
      step(1'b0, 1'b1, 5'd3, 32'h77, 5'd3, 5'd29, 5'd3);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd29, 5'd3);

      // Random traffic, biased toward a few indices so bypass hits are common.
      for (int n = 0; n < 600; n++) begin
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : pick[$urandom_range(0, 7)];
         a1 = ($urandom_range(0, 2) == 0) ? wa : pick[$urandom_range(0, 7)];
         a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), wa, $urandom(),
              a1, a2, ($urandom_range(0, 1) == 0) ? wa : pick[$urandom_range(0, 7)]);
      end

      @(negedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
